// File: rtl/riscv_tmr_pkg.sv
// rtl/riscv_tmr_pkg.sv - shared constants for the triplicated register file
package riscv_tmr_pkg;

    localparam int NUM_REGS = 32;

    // x0 is hardwired to zero, so the scan starts and wraps to x1
    localparam logic [4:0] FIRST_REG = 5'd1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_VOTE  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

endpackage

// File: rtl/tmr_voter32.sv
// rtl/tmr_voter32.sv - combinational 2-of-3 bitwise majority voter
module tmr_voter32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic [31:0] maj,
    output logic        triple
);

    assign maj = (a & b) | (a & c) | (b & c);

    // No two replicas agree on the word, so the majority result cannot be trusted
    assign triple = (a != b) && (a != c) && (b != c);

endmodule

// File: rtl/regfile_scrubber.sv
// rtl/regfile_scrubber.sv - background TMR scrubber for the register file
module regfile_scrubber #(
    parameter int NUM_REGS = riscv_tmr_pkg::NUM_REGS,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             en,
    input  logic             pipe_we,
    input  logic [4:0]       pipe_addr,
    input  logic [31:0]      rd_a,
    input  logic [31:0]      rd_b,
    input  logic [31:0]      rd_c,
    output logic [4:0]       scrub_addr,
    output logic             scrub_we,
    output logic [31:0]      scrub_wd,
    output logic             busy,
    output logic [ERR_W-1:0] err_count,
    output logic             triple_err
);
    import riscv_tmr_pkg::*;

    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [31:0] cap_a;
    logic [31:0] cap_b;
    logic [31:0] cap_c;
    logic        stale;
    logic [31:0] maj;
    logic        triple;
    logic        hit;
    logic        mismatch;
    logic        advance;
    logic        count;
    logic [4:0]  addr_next;
    logic [1:0]  after_reg;

    tmr_voter32 u_voter (
        .a      (cap_a),
        .b      (cap_b),
        .c      (cap_c),
        .maj    (maj),
        .triple (triple)
    );

    assign hit       = pipe_we && (pipe_addr == scrub_addr);
    assign mismatch  = (cap_a != cap_b) || (cap_a != cap_c);
    assign addr_next = (scrub_addr == LAST_REG) ? FIRST_REG : scrub_addr + 5'd1;
    assign after_reg = en ? ST_READ : ST_IDLE;

    // The pipeline owns the shared write port, so the enable must see pipe_we this cycle
    assign scrub_we = (state == ST_WRITE) && !pipe_we;

    always_comb begin
        state_n = state;
        advance = 1'b0;
        count   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_n = ST_READ;
            end
            ST_READ: begin
                state_n = ST_VOTE;
            end
            ST_VOTE: begin
                if (mismatch && !stale && !hit) begin
                    state_n = ST_WRITE;
                end else begin
                    advance = 1'b1;
                    state_n = after_reg;
                end
            end
            ST_WRITE: begin
                if (!pipe_we) begin
                    count   = 1'b1;
                    advance = 1'b1;
                    state_n = after_reg;
                end else if (hit) begin
                    advance = 1'b1;
                    state_n = after_reg;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state      <= ST_IDLE;
            scrub_addr <= FIRST_REG;
            scrub_wd   <= '0;
            busy       <= 1'b0;
            err_count  <= '0;
            triple_err <= 1'b0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_c      <= '0;
            stale      <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != ST_IDLE);
            if (state == ST_READ) begin
                cap_a <= rd_a;
                cap_b <= rd_b;
                cap_c <= rd_c;
                stale <= hit;
            end
            if (advance) scrub_addr <= addr_next;
            if ((state == ST_VOTE) && (state_n == ST_WRITE)) scrub_wd <= maj;
            if ((state == ST_VOTE) && !stale && !hit && triple) triple_err <= 1'b1;
            if (count && !(&err_count)) err_count <= err_count + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_regfile_scrubber.sv
// tb/tb_regfile_scrubber.sv - directed bench for regfile_scrubber
module tb_regfile_scrubber;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        en;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_wd;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic [31:0] rd_c;
    logic [4:0]  scrub_addr;
    logic        scrub_we;
    logic [31:0] scrub_wd;
    logic        busy;
    logic [15:0] err_count;
    logic        triple_err;

    logic [31:0] ra [32];
    logic [31:0] rb [32];
    logic [31:0] rc [32];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rd_a = ra[scrub_addr];
    assign rd_b = rb[scrub_addr];
    assign rd_c = rc[scrub_addr];

    regfile_scrubber dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .en         (en),
        .pipe_we    (pipe_we),
        .pipe_addr  (pipe_addr),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .rd_c       (rd_c),
        .scrub_addr (scrub_addr),
        .scrub_we   (scrub_we),
        .scrub_wd   (scrub_wd),
        .busy       (busy),
        .err_count  (err_count),
        .triple_err (triple_err)
    );

    task automatic init_file();
        for (int i = 0; i < 32; i++) begin
            ra[i] = 32'hA5A5_0000 | 32'(i);
            rb[i] = 32'hA5A5_0000 | 32'(i);
            rc[i] = 32'hA5A5_0000 | 32'(i);
        end
    endtask

    // One clock: checks for port overlap, then applies the register-file writes of that edge
    task automatic step();
        logic        sw;
        logic [4:0]  sa;
        logic [31:0] swd;
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pwd;
        #1;
        sw = scrub_we; sa = scrub_addr; swd = scrub_wd;
        pw = pipe_we;  pa = pipe_addr;  pwd = pipe_wd;
        checks++;
        if (sw === 1'b1 && pw === 1'b1) begin
            failures++;
            $display("FAIL write_overlap scrub_we=%b pipe_we=%b addr=%0d", sw, pw, sa);
        end
        @(posedge clk);
        #1;
        if (sw) begin ra[sa] = swd; rb[sa] = swd; rc[sa] = swd; end
        if (pw && pa != 5'd0) begin ra[pa] = pwd; rb[pa] = pwd; rc[pa] = pwd; end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_scan();
        rst_in = 1'b1; en = 1'b0; pipe_we = 1'b0; pipe_addr = 5'd0; pipe_wd = 32'd0;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        en     = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_in = 1'b1; en = 1'b0; pipe_we = 1'b0; pipe_addr = 5'd0; pipe_wd = 32'd0;
        init_file();
        @(posedge clk);
        #1;
        checks++;
        if ({scrub_addr, scrub_we, busy, triple_err} !== {5'd1, 3'b000}) begin
            failures++;
            $display("FAIL reset_ctrl got addr=%0d we=%b busy=%b tri=%b want 1 0 0 0",
                     scrub_addr, scrub_we, busy, triple_err);
        end
        checks++;
        if (scrub_wd !== 32'd0 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_data got wd=%h cnt=%0d want 0 0", scrub_wd, err_count);
        end
    endtask

    task automatic test_clean_sweep();
        init_file();
        start_scan();
        for (int r = 1; r < 32; r++) begin
            for (int ph = 0; ph < 2; ph++) begin
                checks++;
                if ({scrub_addr, scrub_we, busy} !== {5'(r), 1'b0, 1'b1}) begin
                    failures++;
                    $display("FAIL sweep_r%0d_p%0d got addr=%0d we=%b busy=%b want %0d 0 1",
                             r, ph, scrub_addr, scrub_we, busy, r);
                end
                step();
            end
        end
        checks++;
        if (scrub_addr !== 5'd1 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL sweep_wrap got addr=%0d cnt=%0d want 1 0", scrub_addr, err_count);
        end
    endtask

    task automatic test_single_fix();
        init_file();
        ra[7] = 32'h5; rb[7] = 32'h4; rc[7] = 32'h5;
        start_scan();
        steps(12);
        checks++;
        if (scrub_addr !== 5'd7 || scrub_we !== 1'b0) begin
            failures++;
            $display("FAIL fix_read got addr=%0d we=%b want 7 0", scrub_addr, scrub_we);
        end
        step();
        checks++;
        if (scrub_we !== 1'b0) begin
            failures++;
            $display("FAIL fix_vote got we=%b want 0", scrub_we);
        end
        step();
        checks++;
        if ({scrub_we, scrub_addr, scrub_wd} !== {1'b1, 5'd7, 32'h5}) begin
            failures++;
            $display("FAIL fix_write got we=%b addr=%0d wd=%h want 1 7 5", scrub_we, scrub_addr, scrub_wd);
        end
        step();
        checks++;
        if ({scrub_we, scrub_addr, err_count} !== {1'b0, 5'd8, 16'd1} || rb[7] !== 32'h5) begin
            failures++;
            $display("FAIL fix_after got we=%b addr=%0d cnt=%0d rb7=%h want 0 8 1 5",
                     scrub_we, scrub_addr, err_count, rb[7]);
        end
    endtask

    task automatic test_triple();
        init_file();
        ra[3] = 32'h1; rb[3] = 32'h2; rc[3] = 32'h4;
        start_scan();
        steps(4);
        checks++;
        if (scrub_addr !== 5'd3 || triple_err !== 1'b0) begin
            failures++;
            $display("FAIL triple_pre got addr=%0d tri=%b want 3 0", scrub_addr, triple_err);
        end
        steps(2);
        checks++;
        if ({scrub_we, scrub_wd, triple_err} !== {1'b1, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL triple_write got we=%b wd=%h tri=%b want 1 0 1", scrub_we, scrub_wd, triple_err);
        end
        steps(5);
        checks++;
        if (err_count !== 16'd1 || triple_err !== 1'b1) begin
            failures++;
            $display("FAIL triple_sticky got cnt=%0d tri=%b want 1 1", err_count, triple_err);
        end
    endtask

    task automatic test_yield();
        init_file();
        rb[9] = rb[9] ^ 32'h0000_0100;
        start_scan();
        steps(18);
        for (int i = 0; i < 3; i++) begin
            pipe_we = 1'b1; pipe_addr = 5'd12; pipe_wd = 32'h1234_5678;
            #1;
            checks++;
            if ({scrub_we, busy, scrub_addr} !== {1'b0, 1'b1, 5'd9}) begin
                failures++;
                $display("FAIL yield_hold%0d got we=%b busy=%b addr=%0d want 0 1 9",
                         i, scrub_we, busy, scrub_addr);
            end
            step();
        end
        pipe_we = 1'b0;
        #1;
        checks++;
        if ({scrub_we, scrub_wd} !== {1'b1, 32'hA5A5_0009}) begin
            failures++;
            $display("FAIL yield_write got we=%b wd=%h want 1 a5a50009", scrub_we, scrub_wd);
        end
        step();
        checks++;
        if ({scrub_we, scrub_addr, err_count} !== {1'b0, 5'd10, 16'd1}) begin
            failures++;
            $display("FAIL yield_after got we=%b addr=%0d cnt=%0d want 0 10 1", scrub_we, scrub_addr, err_count);
        end
    endtask

    task automatic test_pipe_hit();
        init_file();
        rc[9] = 32'hDEAD_BEEF;
        start_scan();
        steps(17);
        pipe_we = 1'b1; pipe_addr = 5'd9; pipe_wd = 32'h0BAD_F00D;
        step();
        pipe_we = 1'b0;
        checks++;
        if ({scrub_we, scrub_addr, err_count} !== {1'b0, 5'd10, 16'd0}) begin
            failures++;
            $display("FAIL hit_skip got we=%b addr=%0d cnt=%0d want 0 10 0", scrub_we, scrub_addr, err_count);
        end
        steps(2);
        checks++;
        if (scrub_addr !== 5'd11 || err_count !== 16'd0 || rc[9] !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL hit_after got addr=%0d cnt=%0d rc9=%h want 11 0 0badf00d",
                     scrub_addr, err_count, rc[9]);
        end
    endtask

    task automatic test_en_drop();
        init_file();
        ra[4] = 32'hFFFF_FFFF;
        start_scan();
        steps(7);
        en = 1'b0;
        step();
        checks++;
        if ({scrub_we, busy, scrub_addr} !== {1'b1, 1'b1, 5'd4}) begin
            failures++;
            $display("FAIL drop_write got we=%b busy=%b addr=%0d want 1 1 4", scrub_we, busy, scrub_addr);
        end
        steps(2);
        checks++;
        if ({scrub_we, busy, scrub_addr, err_count} !== {1'b0, 1'b0, 5'd5, 16'd1}) begin
            failures++;
            $display("FAIL drop_idle got we=%b busy=%b addr=%0d cnt=%0d want 0 0 5 1",
                     scrub_we, busy, scrub_addr, err_count);
        end
    endtask

    task automatic test_reset_mid_write();
        init_file();
        rb[5] = 32'h0;
        start_scan();
        steps(10);
        checks++;
        if (scrub_we !== 1'b1) begin
            failures++;
            $display("FAIL rstw_write got we=%b want 1", scrub_we);
        end
        #2;
        rst_in = 1'b1;
        #1;
        checks++;
        if ({scrub_we, busy, scrub_addr, triple_err} !== {1'b0, 1'b0, 5'd1, 1'b0}
            || scrub_wd !== 32'd0 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL rstw_async got we=%b busy=%b addr=%0d wd=%h cnt=%0d want 0 0 1 0 0",
                     scrub_we, busy, scrub_addr, scrub_wd, err_count);
        end
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        en     = 1'b1;
        step();
        checks++;
        if ({busy, scrub_addr} !== {1'b1, 5'd1}) begin
            failures++;
            $display("FAIL rstw_restart got busy=%b addr=%0d want 1 1", busy, scrub_addr);
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_single_fix();
        test_triple();
        test_yield();
        test_pipe_hit();
        test_en_drop();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
